// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake on both sides.
// Single-cycle ops produce their result one edge after accept. MUL runs an
// iterative shift-add and takes WIDTH edges from accept to result.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   in1, in2, sel       operands and op code
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   out, Z, N, C, V     registered result and flags
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;
    localparam logic [3:0] OP_ASR = 4'b1010;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    // Single-cycle datapath
    logic [WIDTH:0]        sum, dif, shl_x, shr_x;
    logic signed [WIDTH:0] asr_x;
    logic                  sh_gt_w;
    logic [WIDTH-1:0]      alu_res;
    logic                  alu_c, alu_v;

    always_comb begin
        sum   = {1'b0, in1} + {1'b0, in2};
        dif   = {1'b0, in1} - {1'b0, in2};
        // The extra bit beside the result catches the last bit shifted out;
        // amounts of 0 or beyond WIDTH naturally leave it zero.
        shl_x = {1'b0, in1} << in2;
        shr_x = {in1, 1'b0} >> in2;
        asr_x = $signed({in1, 1'b0}) >>> in2;
        // ASR keeps shifting copies of the sign into the carry slot, so
        // amounts above WIDTH must clear C explicitly.
        sh_gt_w = (|in2[WIDTH-1:SHW+1]) || (in2[SHW:0] > (SHW+1)'(WIDTH));
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
        case (sel)
            OP_SUB: begin
                alu_res = dif[WIDTH-1:0];
                alu_c   = dif[WIDTH];
                alu_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (dif[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_AND: begin alu_res = in1 & in2; alu_c = 1'b0; alu_v = 1'b0; end
            OP_OR:  begin alu_res = in1 | in2; alu_c = 1'b0; alu_v = 1'b0; end
            OP_XOR: begin alu_res = in1 ^ in2; alu_c = 1'b0; alu_v = 1'b0; end
            OP_SHL: begin alu_res = shl_x[WIDTH-1:0]; alu_c = shl_x[WIDTH]; alu_v = 1'b0; end
            OP_SHR: begin alu_res = shr_x[WIDTH:1];   alu_c = shr_x[0];     alu_v = 1'b0; end
            OP_ASR: begin
                alu_res = asr_x[WIDTH:1];
                alu_c   = asr_x[0] && !sh_gt_w;
                alu_v   = 1'b0;
            end
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            default: ;
        endcase
    end

    // Multiply step. The last MUL cycle also folds in the top multiplier
    // bit, so all WIDTH partial products land within WIDTH edges of accept.
    logic [2*WIDTH-1:0] mcand_x, pp0, pp1, acc_nx;
    logic               mul_last;

    always_comb begin
        mcand_x  = {{WIDTH{1'b0}}, mcand_q};
        mul_last = (cnt_q == SHW'(WIDTH-2));
        pp0      = mplier_q[0] ? (mcand_x << cnt_q) : '0;
        pp1      = (mul_last && mplier_q[1]) ? (mcand_x << (WIDTH-1)) : '0;
        acc_nx   = acc_q + pp0 + pp1;
    end

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (sel == OP_MUL) begin
                        mcand_d  = in1;
                        mplier_d = in2;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = ST_MUL;
                    end else begin
                        out_d   = alu_res;
                        z_d     = (alu_res == '0);
                        n_d     = alu_res[WIDTH-1];
                        c_d     = alu_c;
                        v_d     = alu_v;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_nx;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (mul_last) begin
                    out_d   = acc_nx[WIDTH-1:0];
                    z_d     = (acc_nx[WIDTH-1:0] == '0);
                    n_d     = acc_nx[WIDTH-1];
                    c_d     = |acc_nx[2*WIDTH-1:WIDTH];
                    v_d     = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            z_q         <= 1'b1;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            z_q         <= z_d;
            n_q         <= n_d;
            c_q         <= c_d;
            v_q         <= v_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign C         = c_q;
    assign V         = v_q;
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic [3:0]   sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         Z, N, C, V;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .Z(Z), .N(N), .C(C), .V(V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] out;
        bit           z, n, c, v;
        logic [3:0]   sel;
        int           lat;
        int           acc_e;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   bp_pct = 0;
    bit   bp_hold = 0;
    bit   mon_first = 1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(logic [3:0] s, logic [W-1:0] a, logic [W-1:0] b);
        exp_t   e;
        int     ua = int'(a);
        int     ub = int'(b);
        int     sa = (ua >= 128) ? ua - 256 : ua;
        int     sb = (ub >= 128) ? ub - 256 : ub;
        int     k  = ub;
        longint r  = 0;
        bit     c  = 0;
        bit     v  = 0;
        case (s)
            4'h2: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            4'h3: r = ua & ub;
            4'h4: r = ua | ub;
            4'h5: r = ua ^ ub;
            4'h6: if (k <= W) begin r = longint'(ua) << k; c = ((r >> W) & 1) != 0; end
            4'h7: if (k <= W) begin r = ua >> k; c = (k > 0) && (((ua >> (k - 1)) & 1) != 0); end
            4'h8: begin r = ua * ub; c = (r >= 256); end
            4'h9: r = (sa < sb) ? 1 : 0;
            4'hA: begin
                if (k >= W) r = (sa < 0) ? -1 : 0;
                else        r = sa >>> k;
                c = (k > 0) && (k <= W) && (((ua >> (k - 1)) & 1) != 0);
            end
            default: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
        endcase
        e.out = r[W-1:0];
        e.z   = (e.out == 0);
        e.n   = e.out[W-1];
        e.c   = c;
        e.v   = v;
        e.sel = s;
        e.lat = (s == 4'h8) ? W : 1;
        e.acc_e = 0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (!bp_hold) out_ready = ($urandom_range(99) >= bp_pct);
    endtask

    // Present an op and hold it until accepted; the expectation is queued
    // just before the accepting edge.
    task automatic do_issue(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                            input exp_t e);
        int n = 0;
        sel = s; in1 = a; in2 = b; in_valid = 1'b1;
        while (!in_ready && n < 200) begin tick(); n++; end
        if (!in_ready) begin
            chk("accept_timeout", int'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        e.acc_e = cyc + 1;
        q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        do_issue(s, a, b, model(s, a, b));
    endtask

    task automatic issue_k(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] o, input logic [3:0] zncv);
        exp_t e;
        e.out = o;
        {e.z, e.n, e.c, e.v} = zncv;
        e.sel = s;
        e.lat = (s == 4'h8) ? W : 1;
        e.acc_e = 0;
        do_issue(s, a, b, e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin tick(); n++; end
        chk("drain_timeout", q.size(), 0);
    endtask

    // Monitor: compares every presented result against the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_first = 1;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", int'(out_valid), 0);
            end else begin
                if (mon_first) begin
                    chk($sformatf("op%0h.latency", q[0].sel), cyc - q[0].acc_e, q[0].lat - 1);
                    mon_first = 0;
                end
                chk($sformatf("op%0h.out", q[0].sel), int'(out), int'(q[0].out));
                chk($sformatf("op%0h.Z", q[0].sel), int'(Z), int'(q[0].z));
                chk($sformatf("op%0h.N", q[0].sel), int'(N), int'(q[0].n));
                chk($sformatf("op%0h.C", q[0].sel), int'(C), int'(q[0].c));
                chk($sformatf("op%0h.V", q[0].sel), int'(V), int'(q[0].v));
                chk("in_ready_busy", int'(in_ready), 0);
                if (out_ready) begin
                    void'(q.pop_front());
                    mon_first = 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] s;
        logic [W-1:0] a, b;

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst.in_ready", int'(in_ready), 1);
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.out", int'(out), 0);
        chk("rst.Z", int'(Z), 1);
        chk("rst.N", int'(N), 0);
        chk("rst.C", int'(C), 0);
        chk("rst.V", int'(V), 0);
        tick();

        // Directed vectors with hand-derived expectations: {Z,N,C,V}
        issue_k(4'h0, 8'hFF, 8'h01, 8'h00, 4'b1010); drain();
        issue_k(4'h2, 8'h80, 8'h01, 8'h7F, 4'b0001); drain();
        issue_k(4'h8, 8'h10, 8'h11, 8'h10, 4'b0010); drain();
        issue_k(4'h8, 8'h0F, 8'h0F, 8'hE1, 4'b0100); drain();
        issue_k(4'h6, 8'h81, 8'd1,  8'h02, 4'b0010); drain();
        issue_k(4'h7, 8'h81, 8'd9,  8'h00, 4'b1000); drain();
        issue_k(4'hA, 8'h80, 8'd9,  8'hFF, 4'b0100); drain();
        issue_k(4'hA, 8'h80, 8'd3,  8'hF0, 4'b0100); drain();
        issue_k(4'h9, 8'hFE, 8'h01, 8'h01, 4'b0000); drain();
        issue_k(4'h9, 8'h01, 8'hFE, 8'h00, 4'b1000); drain();
        issue_k(4'h8, 8'hFF, 8'hFF, 8'h01, 4'b0010); drain();

        // Backpressure: result held, a waiting op must not be taken
        bp_hold = 1; out_ready = 1'b0;
        issue_k(4'h0, 8'd3, 8'd4, 8'h07, 4'b0000);
        sel = 4'h2; in1 = 8'h55; in2 = 8'h11; in_valid = 1'b1;
        repeat (5) tick();
        out_ready = 1'b1;
        tick();
        chk("bp.idle_in_ready", int'(in_ready), 1);
        chk("bp.idle_out_valid", int'(out_valid), 0);
        bp_hold = 0;
        issue(4'h2, 8'h55, 8'h11);
        drain();

        // Reset in the middle of the 4th MUL cycle discards the op
        issue(4'h8, 8'h37, 8'h5A);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", int'(out_valid), 0);
        chk("midrst.in_ready", int'(in_ready), 1);
        chk("midrst.out", int'(out), 0);
        chk("midrst.Z", int'(Z), 1);
        q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("midrst.release_in_ready", int'(in_ready), 1);
        repeat (12) tick();
        chk("midrst.no_valid", int'(out_valid), 0);

        // Randomised ops with random backpressure
        bp_pct = 35;
        for (int i = 0; i < 200; i++) begin
            s = 4'($urandom_range(0, 15));
            if (i % 5 == 0) s = 4'h8;
            a = 8'($urandom);
            b = 8'($urandom);
            if ((s == 4'h6 || s == 4'h7 || s == 4'hA) && $urandom_range(1) == 1)
                b = 8'($urandom_range(0, 10));
            issue(s, a, b);
        end
        bp_pct = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
